fp_divider_seq: RTL and testbench

//  Iterative IEEE-754 single-precision divider: quotient = a / b.

---
 rtl/fp_divider_seq.sv | 184 ++++++++++++++++++
 tb/tb_fp_divider_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider (quotient = a / b).
// Restoring division producing one quotient bit per clock, then a single round-to-nearest-even step.
module fp_divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic        U,
    output logic        O,
    output logic        DZ
);
    localparam int unsigned QBITS = 27;

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
    state_t state, state_next;

    logic [23:0]       mb;
    logic [24:0]       rem;
    logic [26:0]       q;
    logic signed [9:0] exp_q;
    logic              sign;
    logic [4:0]        cnt;

    logic [7:0]  ea, eb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_in;
    logic        is_special, spec_dz;
    logic [31:0] spec_q;

    // Operand classification works on the live inputs; it only matters in the accept cycle.
    always_comb begin
        ea         = a[30:23];
        eb         = b[30:23];
        s_in       = a[31] ^ b[31];
        a_zero     = (ea == 8'h00);
        b_zero     = (eb == 8'h00);
        a_inf      = (ea == 8'hFF) && (a[22:0] == 23'h0);
        b_inf      = (eb == 8'hFF) && (b[22:0] == 23'h0);
        a_nan      = (ea == 8'hFF) && (a[22:0] != 23'h0);
        b_nan      = (eb == 8'hFF) && (b[22:0] != 23'h0);
        is_special = 1'b1;
        spec_dz    = 1'b0;
        spec_q     = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q = 32'h7FC0_0000;
        end else if (a_inf) begin
            spec_q = {s_in, 8'hFF, 23'h0};
        end else if (b_inf) begin
            spec_q = {s_in, 31'h0};
        end else if (b_zero) begin
            spec_q  = {s_in, 8'hFF, 23'h0};
            spec_dz = 1'b1;
        end else if (a_zero) begin
            spec_q = {s_in, 31'h0};
        end else begin
            is_special = 1'b0;
        end
    end

    logic        qbit;
    logic [24:0] rem_step;

    always_comb begin
        qbit     = (rem >= {1'b0, mb});
        rem_step = qbit ? (rem - {1'b0, mb}) : rem;
    end

    logic [23:0]       m_n, m_r;
    logic [24:0]       m_sum;
    logic              g_bit, r_bit, s_bit, inc;
    logic signed [9:0] e_n, e_r;
    logic [31:0]       res;
    logic              res_u, res_o;

    always_comb begin
        if (q[26]) begin
            m_n   = q[26:3];
            g_bit = q[2];
            r_bit = q[1];
            s_bit = q[0] | (rem != '0);
            e_n   = exp_q;
        end else begin
            m_n   = q[25:2];
            g_bit = q[1];
            r_bit = q[0];
            s_bit = (rem != '0);
            e_n   = exp_q - 10'sd1;
        end
        inc   = g_bit & (r_bit | s_bit | m_n[0]);
        m_sum = {1'b0, m_n} + {24'h0, inc};
        if (m_sum[24]) begin
            m_r = 24'h80_0000;
            e_r = e_n + 10'sd1;
        end else begin
            m_r = m_sum[23:0];
            e_r = e_n;
        end
        res_u = 1'b0;
        res_o = 1'b0;
        if (e_r >= 10'sd255) begin
            res   = {sign, 8'hFF, 23'h0};
            res_o = 1'b1;
        end else if (e_r <= 10'sd0) begin
            res   = {sign, 31'h0};
            res_u = 1'b1;
        end else begin
            res = {sign, e_r[7:0], m_r[22:0]};
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE:    if (start) state_next = is_special ? DONE : DIVIDE;
            DIVIDE: begin
                busy = 1'b1;
                if (cnt == 5'd0) state_next = ROUND;
            end
            ROUND: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mb       <= '0;
            rem      <= '0;
            q        <= '0;
            exp_q    <= '0;
            sign     <= 1'b0;
            cnt      <= '0;
            quotient <= '0;
            U        <= 1'b0;
            O        <= 1'b0;
            DZ       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    mb    <= {1'b1, b[22:0]};
                    rem   <= {2'b01, a[22:0]};
                    q     <= '0;
                    exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                    sign  <= s_in;
                    cnt   <= 5'(QBITS - 1);
                    if (is_special) begin
                        quotient <= spec_q;
                        U        <= 1'b0;
                        O        <= 1'b0;
                        DZ       <= spec_dz;
                    end
                end
                DIVIDE: begin
                    q   <= {q[25:0], qbit};
                    rem <= {rem_step[23:0], 1'b0};
                    cnt <= cnt - 5'd1;
                end
                ROUND: begin
                    quotient <= res;
                    U        <= res_u;
                    O        <= res_o;
                    DZ       <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_divider_seq.sv
// Randomized self-checking bench for fp_divider_seq against an integer-arithmetic reference model.
module tb_fp_divider_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] quotient;
    logic        U, O, DZ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_divider_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quotient(quotient), .U(U), .O(O), .DZ(DZ)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {special, U, O, DZ, quotient}; the quotient is one exact integer division.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic s, xz, yz, xi, yi, xn, yn;
        int ex, ey, e, sh;
        longint unsigned num, den, qq, rr, m, tail, half2;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 23'h0);
        yi = (ey == 255) && (y[22:0] == 23'h0);
        xn = (ex == 255) && (x[22:0] != 23'h0);
        yn = (ey == 255) && (y[22:0] != 23'h0);
        if (xn || yn || (xz && yz) || (xi && yi)) return {4'b1000, 32'h7FC00000};
        if (xi) return {4'b1000, s, 8'hFF, 23'h0};
        if (yi) return {4'b1000, s, 31'h0};
        if (yz) return {4'b1001, s, 8'hFF, 23'h0};
        if (xz) return {4'b1000, s, 31'h0};
        num = (longint'(x[22:0]) + 64'h800000) << 26;
        den = longint'(y[22:0]) + 64'h800000;
        qq  = num / den;
        rr  = num % den;
        e   = ex - ey + 127;
        sh  = (qq >= (64'd1 << 26)) ? 3 : 2;
        if (sh == 2) e = e - 1;
        m     = qq >> sh;
        tail  = ((qq & ((64'd1 << sh) - 64'd1)) << 1) | 64'(rr != 0);
        half2 = 64'd1 << sh;
        if (tail > half2 || (tail == half2 && m[0])) m = m + 64'd1;
        if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0100, s, 31'h0};
        return {4'b0000, s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        int c;
        c = $urandom_range(0, 15);
        m = 23'($urandom);
        e = 8'($urandom_range(100, 154));
        case (c)
            0: e = 8'h00;
            1: begin e = 8'hFF; m = '0; end
            2: begin e = 8'hFF; m[22] = 1'b1; end
            3: e = 8'($urandom_range(250, 254));
            4: e = 8'($urandom_range(1, 5));
            5: m = '1;
            6: m = '0;
            default: ;
        endcase
        return {1'($urandom), e, m};
    endfunction

    // mode 0: plain divide; 1: second start pulse at T+5; 2: reset at T+10.
    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input int mode,
                           output logic [31:0] q_obs, output logic [2:0] f_obs);
        logic [35:0] exp_r;
        int lat, k, busy_bad;
        bit seen;
        exp_r    = model(x, y);
        lat      = exp_r[35] ? 1 : 29;
        busy_bad = 0;
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        for (k = 1; k <= 40; k++) begin
            if (mode == 2 && k == 11) break;
            if (done) break;
            if (busy !== (k < lat)) busy_bad++;
            a     = $urandom;
            b     = $urandom;
            start = (mode == 1 && k == 5);
            rst   = (mode == 2 && k == 10);
            @(negedge clk);
        end
        start = 1'b0;
        if (mode == 2) begin
            rst = 1'b0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_quot", quotient, 32'h0);
            check("rst_flags", 32'({U, O, DZ}), 32'd0);
            seen = 0;
            for (int j = 0; j < 35; j++) begin
                if (done) seen = 1;
                @(negedge clk);
            end
            check("no_done_after_rst", 32'(seen), 32'd0);
            q_obs = quotient;
            f_obs = {U, O, DZ};
            return;
        end
        check("latency", 32'(k), 32'(lat));
        check("busy_profile", 32'(busy_bad), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
        check($sformatf("quot %h/%h", x, y), quotient, exp_r[31:0]);
        check($sformatf("flags %h/%h", x, y), 32'({U, O, DZ}), 32'(exp_r[34:32]));
        q_obs = quotient;
        f_obs = {U, O, DZ};
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("hold_quot", quotient, exp_r[31:0]);
    endtask

    logic [31:0] qo;
    logic [2:0]  fo;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quot", quotient, 32'h0);
        check("reset_flags", 32'({U, O, DZ}), 32'd0);
        rst = 1'b0;

        run_div(32'h40C00000, 32'h40000000, 0, qo, fo);
        check("six_by_two", qo, 32'h40400000);
        run_div(32'h3F800000, 32'h40400000, 0, qo, fo);
        check("one_third", qo, 32'h3EAAAAAB);
        run_div(32'h3F800000, 32'h00000000, 0, qo, fo);
        check("dz_pos", qo, 32'h7F800000);
        check("dz_pos_flag", 32'(fo), 32'd1);
        run_div(32'hBF800000, 32'h00000000, 0, qo, fo);
        check("dz_neg", qo, 32'hFF800000);
        run_div(32'h7F000000, 32'h00800000, 0, qo, fo);
        check("overflow", qo, 32'h7F800000);
        check("overflow_flag", 32'(fo), 32'd2);
        run_div(32'h00800000, 32'h40000000, 0, qo, fo);
        check("underflow", qo, 32'h00000000);
        check("underflow_flag", 32'(fo), 32'd4);
        run_div(32'h7FC00000, $urandom, 0, qo, fo);
        check("nan_in", qo, 32'h7FC00000);

        run_div(32'h40C00000, 32'h40000000, 1, qo, fo);
        check("restart_ignored", qo, 32'h40400000);
        run_div(32'h40C00000, 32'h40000000, 2, qo, fo);
        run_div(32'h3F800000, 32'h40400000, 0, qo, fo);
        check("after_reset", qo, 32'h3EAAAAAB);

        for (int i = 0; i < 300; i++) begin
            run_div(rand_op(), rand_op(), 0, qo, fo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
